systolic_seq_ctrl: RTL and testbench

//  Job sequencer for a weight-stationary ROWS x COLS systolic PE array: loads the stationary

---
 rtl/systolic_seq_ctrl_pkg.sv | 31 +++
 rtl/systolic_seq_ctrl_skew_window.sv | 20 ++
 rtl/systolic_seq_ctrl.sv | 157 +++++++++++++++
 tb/tb_systolic_seq_ctrl.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/systolic_seq_ctrl_pkg.sv
// Shared types and width helpers for the systolic array job sequencer.
package systolic_seq_ctrl_pkg;

  typedef enum logic [1:0] {
    MUX_HOLD        = 2'd0,
    MUX_PASSTHROUGH = 2'd1,
    MUX_LOAD        = 2'd2,
    MUX_PROCESS     = 2'd3
  } input_mux_t;

  typedef enum logic [1:0] {
    S_IDLE       = 2'd0,
    S_LOADING    = 2'd1,
    S_PROCESSING = 2'd2,
    S_END        = 2'd3
  } state_t;

  function automatic int calc_kw(input int max_k);
    return $clog2(max_k + 1);
  endfunction

  function automatic int calc_tw(input int rows, input int cols, input int max_k);
    return $clog2(rows + cols + max_k);
  endfunction

  // Keeps the load counter at least one bit wide for a single-row array.
  function automatic int calc_lw(input int rows);
    return (rows > 1) ? $clog2(rows) : 1;
  endfunction

endpackage

// File: rtl/systolic_seq_ctrl_skew_window.sv
// Per-lane activity window: lane i is active for len steps starting at step BASE+i.
module systolic_seq_ctrl_skew_window #(
  parameter int W    = 4,
  parameter int TW   = 4,
  parameter int BASE = 0
) (
  input  logic [TW-1:0] t_i,
  input  logic [TW-1:0] len_i,
  output logic [W-1:0]  win_o
);

  // One extra bit so BASE+i+len cannot wrap.
  localparam int XW = TW + 1;

  for (genvar i = 0; i < W; i++) begin : g_win
    localparam logic [XW-1:0] LO = XW'(BASE + i);
    assign win_o[i] = ({1'b0, t_i} >= LO) && ({1'b0, t_i} < (LO + {1'b0, len_i}));
  end

endmodule

// File: rtl/systolic_seq_ctrl.sv
// Weight-stationary systolic array job sequencer: stationary load, skewed stream, handshake.
module systolic_seq_ctrl
  import systolic_seq_ctrl_pkg::*;
#(
  parameter int  ROWS  = 4,
  parameter int  COLS  = 4,
  parameter int  MAX_K = 64,
  localparam int KW    = calc_kw(MAX_K),
  localparam int TW    = calc_tw(ROWS, COLS, MAX_K)
) (
  input  logic                             clk_i,
  input  logic                             rst_i,
  input  logic                             start_i,
  input  logic [KW-1:0]                    k_len_i,
  input  logic                             stall_i,
  input  logic                             abort_i,
  output logic                             busy_o,
  output logic                             done_o,
  output input_mux_t [ROWS-1:0][COLS-1:0]  mux_o,
  output logic [ROWS-1:0][COLS-1:0]        add_zero_o,
  output logic [ROWS-1:0]                  feed_valid_o,
  output logic [COLS-1:0]                  acc_valid_o
);

  localparam int LW = calc_lw(ROWS);

  state_t          state_q, state_d;
  logic [LW-1:0]   l_q, l_d;
  logic [TW-1:0]   t_q, t_d;
  logic [KW-1:0]   k_q, k_d;
  logic            hold_d;
  logic [TW-1:0]   t_last;
  logic [TW-1:0]   k_ext;

  input_mux_t [ROWS-1:0][COLS-1:0] mux_q, mux_d;
  logic [ROWS-1:0][COLS-1:0]       add_zero_q, add_zero_d;
  logic [ROWS-1:0]                 feed_q, feed_d, feed_win;
  logic [COLS-1:0]                 acc_q, acc_d, acc_win;
  logic                            done_q, done_d;
  logic                            proc_en;

  assign t_last = TW'(ROWS + COLS - 2) + TW'(k_q);
  assign k_ext  = TW'(k_d);

  always_comb begin
    state_d = state_q;
    l_d     = l_q;
    t_d     = t_q;
    k_d     = k_q;
    hold_d  = 1'b0;
    if (state_q != S_IDLE && abort_i) begin
      state_d = S_IDLE;
      l_d     = '0;
      t_d     = '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (start_i && k_len_i != '0) begin
            state_d = S_LOADING;
            l_d     = '0;
            t_d     = '0;
            k_d     = (k_len_i > KW'(MAX_K)) ? KW'(MAX_K) : k_len_i;
          end
        end
        S_LOADING: begin
          if (stall_i) begin
            hold_d = 1'b1;
          end else if (l_q == LW'(ROWS - 1)) begin
            state_d = S_PROCESSING;
            l_d     = '0;
            t_d     = '0;
          end else begin
            l_d = l_q + LW'(1);
          end
        end
        S_PROCESSING: begin
          if (stall_i) begin
            hold_d = 1'b1;
          end else if (t_q == t_last) begin
            state_d = S_END;
            t_d     = '0;
          end else begin
            t_d = t_q + TW'(1);
          end
        end
        S_END:   state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  systolic_seq_ctrl_skew_window #(.W(ROWS), .TW(TW), .BASE(0)) u_feed_win (
    .t_i   (t_d),
    .len_i (k_ext),
    .win_o (feed_win)
  );

  systolic_seq_ctrl_skew_window #(.W(COLS), .TW(TW), .BASE(ROWS)) u_acc_win (
    .t_i   (t_d),
    .len_i (k_ext),
    .win_o (acc_win)
  );

  // Outputs decode the post-edge state so they line up with the step being issued.
  always_comb begin
    proc_en    = (state_d == S_PROCESSING) && !hold_d;
    done_d     = (state_d == S_END);
    add_zero_d = '0;
    feed_d     = proc_en ? feed_win : '0;
    acc_d      = proc_en ? acc_win : '0;
    for (int r = 0; r < ROWS; r++) begin
      for (int c = 0; c < COLS; c++) begin
        mux_d[r][c] = MUX_HOLD;
        if (state_d == S_LOADING && !hold_d) begin
          mux_d[r][c] = (l_d == LW'(ROWS - 1)) ? MUX_LOAD : MUX_PASSTHROUGH;
        end else if (proc_en) begin
          mux_d[r][c] = MUX_PROCESS;
        end
      end
    end
    if (proc_en) begin
      add_zero_d[0] = '1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= S_IDLE;
      l_q        <= '0;
      t_q        <= '0;
      k_q        <= '0;
      mux_q      <= '0;
      add_zero_q <= '0;
      feed_q     <= '0;
      acc_q      <= '0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      l_q        <= l_d;
      t_q        <= t_d;
      k_q        <= k_d;
      mux_q      <= mux_d;
      add_zero_q <= add_zero_d;
      feed_q     <= feed_d;
      acc_q      <= acc_d;
      done_q     <= done_d;
    end
  end

  assign busy_o       = (state_q != S_IDLE);
  assign done_o       = done_q;
  assign mux_o        = mux_q;
  assign add_zero_o   = add_zero_q;
  assign feed_valid_o = feed_q;
  assign acc_valid_o  = acc_q;

endmodule

// File: tb/tb_systolic_seq_ctrl.sv
// Scoreboard bench for systolic_seq_ctrl against a step-list job model.
module tb_systolic_seq_ctrl;
  import systolic_seq_ctrl_pkg::*;

  localparam int ROWS  = 4;
  localparam int COLS  = 4;
  localparam int MAX_K = 8;
  localparam int KW    = calc_kw(MAX_K);

  logic clk_i = 1'b0;
  logic rst_i, start_i, stall_i, abort_i;
  logic [KW-1:0] k_len_i;
  logic busy_o, done_o;
  input_mux_t [ROWS-1:0][COLS-1:0] mux_o;
  logic [ROWS-1:0][COLS-1:0] add_zero_o;
  logic [ROWS-1:0] feed_valid_o;
  logic [COLS-1:0] acc_valid_o;

  always #5 clk_i = ~clk_i;

  systolic_seq_ctrl #(.ROWS(ROWS), .COLS(COLS), .MAX_K(MAX_K)) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .start_i      (start_i),
    .k_len_i      (k_len_i),
    .stall_i      (stall_i),
    .abort_i      (abort_i),
    .busy_o       (busy_o),
    .done_o       (done_o),
    .mux_o        (mux_o),
    .add_zero_o   (add_zero_o),
    .feed_valid_o (feed_valid_o),
    .acc_valid_o  (acc_valid_o)
  );

  typedef struct packed {
    logic                           busy;
    logic                           done;
    logic [ROWS*COLS-1:0][1:0]      mux;
    logic [ROWS*COLS-1:0]           az;
    logic [ROWS-1:0]                feed;
    logic [COLS-1:0]                acc;
  } frame_t;

  // kind: 0 = load step, 1 = process step, 2 = end step
  typedef struct {
    int kind;
    int idx;
  } step_t;

  frame_t act;
  assign act = {busy_o, done_o, mux_o, add_zero_o, feed_valid_o, acc_valid_o};

  step_t  steps[$];
  frame_t exp_q[$];
  bit     active = 1'b0;
  int     last_kind = 0;
  int     job_k = 0;
  int     checks = 0;
  int     errors = 0;
  int     busy_cycles = 0;
  int     done_cnt = 0;

  function automatic frame_t issue(input step_t s);
    frame_t f;
    f = '0;
    f.busy = 1'b1;
    case (s.kind)
      0: for (int i = 0; i < ROWS*COLS; i++)
           f.mux[i] = (s.idx == ROWS-1) ? MUX_LOAD : MUX_PASSTHROUGH;
      1: begin
        for (int i = 0; i < ROWS*COLS; i++) f.mux[i] = MUX_PROCESS;
        for (int c = 0; c < COLS; c++) f.az[c] = 1'b1;
        for (int r = 0; r < ROWS; r++) f.feed[r] = (s.idx >= r) && (s.idx < r + job_k);
        for (int c = 0; c < COLS; c++)
          f.acc[c] = (s.idx >= ROWS + c) && (s.idx < ROWS + c + job_k);
      end
      default: f.done = 1'b1;
    endcase
    return f;
  endfunction

  task automatic model_edge(input bit st, input int k, input bit sl, input bit ab,
                            output frame_t f);
    step_t s;
    f = '0;
    if (!active) begin
      if (st && k != 0) begin
        job_k = (k > MAX_K) ? MAX_K : k;
        steps.delete();
        for (int l = 0; l < ROWS; l++) steps.push_back('{0, l});
        for (int t = 0; t < ROWS + COLS + job_k - 1; t++) steps.push_back('{1, t});
        steps.push_back('{2, 0});
        active = 1'b1;
        s = steps.pop_front();
        last_kind = s.kind;
        f = issue(s);
      end
    end else if (ab) begin
      active = 1'b0;
      steps.delete();
    end else if (sl && last_kind != 2) begin
      f.busy = 1'b1;
    end else if (steps.size() == 0) begin
      active = 1'b0;
    end else begin
      s = steps.pop_front();
      last_kind = s.kind;
      f = issue(s);
    end
  endtask

  task automatic cyc(input bit st, input int k, input bit sl, input bit ab);
    frame_t f;
    start_i = st;
    k_len_i = k[KW-1:0];
    stall_i = sl;
    abort_i = ab;
    model_edge(st, k, sl, ab, f);
    @(posedge clk_i);
    exp_q.push_back(f);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) cyc(1'b0, 0, 1'b0, 1'b0);
  endtask

  task automatic drain();
    @(negedge clk_i);
    #1;
  endtask

  task automatic clear_counts();
    busy_cycles = 0;
    done_cnt = 0;
  endtask

  task automatic chk(input string name, input logic [63:0] actual, input logic [63:0] required);
    checks++;
    if (actual !== required) begin
      errors++;
      $display("FAIL %s: actual %0h required %0h", name, actual, required);
    end
  endtask

  always @(negedge clk_i) begin
    frame_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (act !== e) begin
        errors++;
        $display("FAIL frame @%0t: actual %h required %h", $time, act, e);
      end
      if (busy_o) busy_cycles++;
      if (done_o) done_cnt++;
    end
  end

  initial begin
    rst_i = 1'b1;
    start_i = 1'b0;
    k_len_i = '0;
    stall_i = 1'b0;
    abort_i = 1'b0;
    repeat (2) @(posedge clk_i);
    #1;
    chk("reset_outputs", 64'(act), 64'd0);
    rst_i = 1'b0;

    clear_counts();
    cyc(1'b1, 3, 1'b0, 1'b0);
    idle(18);
    drain();
    chk("k3_busy", 64'(busy_cycles), 64'd15);
    chk("k3_done", 64'(done_cnt), 64'd1);

    clear_counts();
    cyc(1'b1, 3, 1'b0, 1'b0);
    idle(8);
    repeat (2) cyc(1'b0, 0, 1'b1, 1'b0);
    idle(20);
    drain();
    chk("stall_busy", 64'(busy_cycles), 64'd17);
    chk("stall_done", 64'(done_cnt), 64'd1);

    clear_counts();
    cyc(1'b1, 3, 1'b0, 1'b0);
    idle(2);
    cyc(1'b1, 3, 1'b0, 1'b1);
    idle(2);
    drain();
    chk("abort_busy", 64'(busy_cycles), 64'd3);
    chk("abort_done", 64'(done_cnt), 64'd0);
    clear_counts();
    cyc(1'b1, 1, 1'b0, 1'b0);
    idle(16);
    drain();
    chk("k1_busy", 64'(busy_cycles), 64'd13);
    chk("k1_done", 64'(done_cnt), 64'd1);

    clear_counts();
    cyc(1'b1, 0, 1'b0, 1'b0);
    idle(3);
    drain();
    chk("k0_busy", 64'(busy_cycles), 64'd0);

    clear_counts();
    cyc(1'b1, 15, 1'b0, 1'b0);
    repeat (5) cyc(1'b1, 2, 1'b0, 1'b0);
    idle(25);
    drain();
    chk("clamp_busy", 64'(busy_cycles), 64'd20);
    chk("clamp_done", 64'(done_cnt), 64'd1);

    clear_counts();
    repeat (15) cyc(1'b1, 1, 1'b0, 1'b0);
    idle(20);
    drain();
    chk("held_start_busy", 64'(busy_cycles), 64'd26);
    chk("held_start_done", 64'(done_cnt), 64'd2);

    cyc(1'b1, 5, 1'b0, 1'b0);
    idle(8);
    drain();
    chk("pre_reset_busy", 64'(busy_o), 64'd1);
    rst_i = 1'b1;
    #1;
    chk("async_reset_outputs", 64'(act), 64'd0);
    active = 1'b0;
    steps.delete();
    @(negedge clk_i);
    rst_i = 1'b0;
    #1;

    repeat (400) begin
      cyc(($urandom_range(0, 3) == 0), int'($urandom_range(0, 15)),
          ($urandom_range(0, 4) == 0), ($urandom_range(0, 30) == 0));
    end
    idle(30);
    drain();
    chk("queue_drained", 64'(exp_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
